// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state encoding and drain-length helper for the systolic feeder
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, STREAM} state_t;
  function automatic int drain_len(input int rows, input int cols, input int mult_lat, input int acc_lat);
    return rows + cols - 2 + mult_lat + acc_lat;
  endfunction
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register cleared to zero by reset
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  // shift one stage per cycle, zeroing the whole line on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B k-steps into a systolic array and sequences clear/drain/stream (optional FEEDER_PERF_CNT_EN adds perf_bubbles)
module systolic_feeder import systolic_pkg::*; #(
  parameter int IN_WIDTH = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int MULT_LAT = 3,
  parameter int ACC_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH*ROWS-1:0] in_a,
  input  logic [IN_WIDTH*COLS-1:0] in_b,
  input  logic                     in_last,
  output logic [IN_WIDTH*ROWS-1:0] row_data_out,
  output logic [IN_WIDTH*COLS-1:0] col_data_out,
  output logic                     rst_accumulator_rdy,
  output logic                     stream_out_rdy,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]              perf_bubbles
`endif
);
  localparam int DL = drain_len(ROWS, COLS, MULT_LAT, ACC_LAT);
  localparam int CW = DL > 1 ? $clog2(DL) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic xfer;
  assign xfer = in_valid && in_ready;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state and per-state strobes
  always_comb begin
    nxt = state;
    in_ready = 1'b0;
    rst_accumulator_rdy = 1'b0;
    stream_out_rdy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:   nxt = in_valid ? CLEAR : IDLE;
      CLEAR:  begin rst_accumulator_rdy = 1'b1; nxt = FEED; end
      FEED:   begin in_ready = 1'b1; nxt = (in_valid && in_last) ? DRAIN : FEED; end
      DRAIN:  nxt = (cnt == '0) ? STREAM : DRAIN;
      STREAM: begin stream_out_rdy = 1'b1; done = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end
  // drain down-counter, preloaded throughout FEED so DRAIN lasts exactly DL cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == FEED) cnt <= CW'(DL - 1);
    else if (state == DRAIN && cnt != '0) cnt <= cnt - CW'(1);
`ifdef FEEDER_PERF_CNT_EN
  // count FEED cycles with no offered k-step, saturating
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_bubbles <= '0;
    else if (state == CLEAR) perf_bubbles <= '0;
    else if (state == FEED && !in_valid && !(&perf_bubbles)) perf_bubbles <= perf_bubbles + 32'd1;
`endif
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(.WIDTH(IN_WIDTH), .DEPTH(r + 1)) u_skew (
      .clk(clk), .rst_n(rst_n),
      .d(xfer ? in_a[IN_WIDTH*r +: IN_WIDTH] : '0),
      .q(row_data_out[IN_WIDTH*r +: IN_WIDTH])
    );
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_delay_line #(.WIDTH(IN_WIDTH), .DEPTH(c + 1)) u_skew (
      .clk(clk), .rst_n(rst_n),
      .d(xfer ? in_b[IN_WIDTH*c +: IN_WIDTH] : '0),
      .q(col_data_out[IN_WIDTH*c +: IN_WIDTH])
    );
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, width of one operand element.
REQ-002 SHALL have parameter ROWS, default 4, number of array rows (A lanes).
REQ-003 SHALL have parameter COLS, default 4, number of array columns (B lanes).
REQ-004 SHALL have parameter MULT_LAT, default 3, array multiplier latency in cycles.
REQ-005 SHALL have parameter ACC_LAT, default 1, array accumulate latency in cycles.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_valid  input  1  producer presents one k-step (A column, B row).
REQ-009 SHALL have port in_ready  output  1  feeder accepts the k-step this cycle.
REQ-010 SHALL have port in_a  input  IN_WIDTH*ROWS  A elements; lane r at bits [IN_WIDTH*r +: IN_WIDTH].
REQ-011 SHALL have port in_b  input  IN_WIDTH*COLS  B elements; lane c at bits [IN_WIDTH*c +: IN_WIDTH].
REQ-012 SHALL have port in_last  input  1  marks the final k-step of a tile.
REQ-013 SHALL have port row_data_out  output  IN_WIDTH*ROWS  skewed A to the array row inputs.
REQ-014 SHALL have port col_data_out  output  IN_WIDTH*COLS  skewed B to the array column inputs.
REQ-015 SHALL have port rst_accumulator_rdy  output  1  one-cycle accumulator-clear pulse to the array.
REQ-016 SHALL have port stream_out_rdy  output  1  one-cycle result-stream pulse to the array.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the tile sequence completes.

Function
REQ-019 SHALL run FSM IDLE->CLEAR->FEED->DRAIN->STREAM->IDLE.
REQ-020 SHALL leave IDLE on in_valid=1, without accepting that beat.
REQ-021 SHALL stay in CLEAR exactly 1 cycle and assert rst_accumulator_rdy only in that cycle.
REQ-022 SHALL drive in_ready=1 only in FEED; a k-step transfers when in_valid&in_ready.
REQ-023 SHALL delay A lane r by r cycles and B lane c by c cycles (lane 0 registered once, zero added skew).
REQ-024 SHALL inject zero into every skew line in any cycle without a transfer, including FEED bubbles.
REQ-025 SHALL go FEED->DRAIN on the cycle after a transfer with in_last=1.
REQ-026 SHALL hold DRAIN for exactly ROWS+COLS-2+MULT_LAT+ACC_LAT cycles via a down-counter, feeding zeros.
REQ-027 SHALL assert stream_out_rdy for exactly the 1 cycle in STREAM, then pulse done and return to IDLE in the same cycle.
REQ-028 SHALL accept a tile of a single k-step (in_last on the first beat).
REQ-029 SHALL place the first A lane-0 element on row_data_out exactly 1 cycle after its transfer.
REQ-030 SHALL ignore in_valid outside FEED, with no effect on outputs.

Reset
REQ-031 SHALL, on rst_n=0, immediately force IDLE, clear all skew registers and counters, and drive every output to 0.
REQ-032 SHALL, on reset asserted mid-tile, discard the tile; no stream_out_rdy or done pulse for it.
REQ-033 SHALL release reset synchronously, so the first state change comes on the clk edge after rst_n rises.

Configuration
REQ-034 SHALL, with FEEDER_PERF_CNT_EN defined, add output perf_bubbles (32 bits): counts FEED cycles with in_valid=0, cleared in CLEAR and by reset, saturating at all-ones.
REQ-035 SHALL, with FEEDER_PERF_CNT_EN undefined, omit the perf_bubbles port and counter entirely, leaving function otherwise identical.

Structure
REQ-036 SHALL take the FSM state enum and the drain-length function (ROWS+COLS-2+MULT_LAT+ACC_LAT) from shared package systolic_pkg.
REQ-037 SHALL use sub-module skew_delay_line (parameters WIDTH, DEPTH; zero-on-reset shift register), one instance per lane.

Verification
REQ-038 SHALL cover: ROWS=COLS=4, 4 back-to-back beats A=B=1..4 -> row_data_out lane 3 shows 1,2,3,4 on cycles 4..7 after the first transfer; one rst_accumulator_rdy pulse before it.
REQ-039 SHALL cover: in_valid low for 2 cycles mid-FEED -> zeros appear in all lanes at the skewed positions; perf_bubbles=2 with FEEDER_PERF_CNT_EN.
REQ-040 SHALL cover: single beat with in_last=1 -> DRAIN lasts 10 cycles (4+4-2+3+1), then stream_out_rdy and done each pulse exactly once.
REQ-041 SHALL cover: rst_n low during DRAIN -> all outputs 0 at once, no done pulse, busy=0.
REQ-042 SHALL cover: in_valid held high in IDLE/DRAIN/STREAM -> in_ready=0 and no lane data changes except the zero fill.
